// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the mem_arb memory-port arbiter.
//   ADDR_W / DATA_W : memory address and data widths
//   WD_W            : watchdog counter width
//   state_e         : arbiter FSM states (idle, serving fetch, serving data)
//   SIDE_I / SIDE_D : requester identifiers used for round-robin bookkeeping
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned WD_W   = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2
    } state_e;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: bundles the fetch, data and memory-side signals of the arbiter.
//   fetch  : i_addr, i_rd -> i_dataout, i_done, i_stall
//   data   : d_addr, d_datain, d_rd, d_wr -> d_dataout, d_done, d_stall
//   memory : m_addr, m_datain, m_rd, m_wr -> m_dataout, m_done, m_err
//   err    : memory error OR sticky arbiter error
// Modport slave is the arbiter's view; master is the view of everything around it.
interface mem_arb_if;
    import mem_arb_pkg::*;

    logic [ADDR_W-1:0] i_addr;
    logic              i_rd;
    logic [DATA_W-1:0] i_dataout;
    logic              i_done;
    logic              i_stall;

    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_datain;
    logic              d_rd;
    logic              d_wr;
    logic [DATA_W-1:0] d_dataout;
    logic              d_done;
    logic              d_stall;

    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_datain;
    logic              m_rd;
    logic              m_wr;
    logic [DATA_W-1:0] m_dataout;
    logic              m_done;
    logic              m_err;

    logic              err;

    modport slave (
        input  i_addr, i_rd, d_addr, d_datain, d_rd, d_wr, m_dataout, m_done, m_err,
        output i_dataout, i_done, i_stall, d_dataout, d_done, d_stall,
               m_addr, m_datain, m_rd, m_wr, err
    );

    modport master (
        output i_addr, i_rd, d_addr, d_datain, d_rd, d_wr, m_dataout, m_done, m_err,
        input  i_dataout, i_done, i_stall, d_dataout, d_done, d_stall,
               m_addr, m_datain, m_rd, m_wr, err
    );

endinterface

// File: rtl/mem_arb_wdog.sv
// arb_wdog: transaction watchdog for mem_arb.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : zero the counter (held while no transaction is in flight)
//   en       : count this cycle (busy and memory not done)
//   expire   : the current counting cycle is the TIMEOUT-th one
module arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WD_W-1:0] LastCnt = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en & (cnt_q == LastCnt);

endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares one mem_system port between instruction fetch and data access.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : mem_arb_if.slave carrying the fetch, data and memory signals
//   TIMEOUT  : busy cycles without m_done before the transaction is abandoned (2..255)
// A granted request is latched into cmd_* and held on the memory port until m_done;
// done/data go back only to the granted side. Ties alternate via last_grant. A hung
// transaction or an illegal simultaneous d_rd/d_wr sets a sticky error.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic              err_q, err_d;

    logic              req_i, req_d, d_illegal, busy;
    logic              wd_clr, wd_en, wd_expire;

    logic              m_rd, m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_datain;
    logic              i_done, d_done;
    logic [DATA_W-1:0] i_dataout, d_dataout;

    assign req_i     = bus.i_rd;
    assign req_d     = bus.d_rd ^ bus.d_wr;
    assign d_illegal = bus.d_rd & bus.d_wr;
    assign busy      = (state_q != StIdle);

    // Counter sits at zero while idle, so it reads zero on the first busy cycle.
    assign wd_clr = ~busy;
    assign wd_en  = busy & ~bus.m_done;

    arb_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_data_d   = cmd_data_q;
        cmd_wr_d     = cmd_wr_q;
        err_d        = err_q;
        m_rd         = 1'b0;
        m_wr         = 1'b0;
        m_addr       = '0;
        m_datain     = '0;
        i_done       = 1'b0;
        i_dataout    = '0;
        d_done       = 1'b0;
        d_dataout    = '0;

        unique case (state_q)
            StIdle: begin
                if (d_illegal) begin
                    err_d = 1'b1;
                end
                // Fetch wins when alone or when data was served last.
                if (req_i && (!req_d || last_grant_q == SIDE_D)) begin
                    state_d      = StBusyI;
                    last_grant_d = SIDE_I;
                    cmd_addr_d   = bus.i_addr;
                    cmd_data_d   = '0;
                    cmd_wr_d     = 1'b0;
                end else if (req_d) begin
                    state_d      = StBusyD;
                    last_grant_d = SIDE_D;
                    cmd_addr_d   = bus.d_addr;
                    cmd_data_d   = bus.d_datain;
                    cmd_wr_d     = bus.d_wr;
                end
            end
            StBusyI, StBusyD: begin
                m_rd     = ~cmd_wr_q;
                m_wr     = cmd_wr_q;
                m_addr   = cmd_addr_q;
                m_datain = cmd_data_q;
                if (bus.m_done) begin
                    state_d = StIdle;
                    if (state_q == StBusyI) begin
                        i_done    = 1'b1;
                        i_dataout = bus.m_dataout;
                    end else begin
                        d_done    = 1'b1;
                        d_dataout = cmd_wr_q ? '0 : bus.m_dataout;
                    end
                end else if (wd_expire) begin
                    // Abandon the hung command without signalling completion.
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= SIDE_D;
            cmd_addr_q   <= '0;
            cmd_data_q   <= '0;
            cmd_wr_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_data_q   <= cmd_data_d;
            cmd_wr_q     <= cmd_wr_d;
            err_q        <= err_d;
        end
    end

    assign bus.m_rd      = m_rd;
    assign bus.m_wr      = m_wr;
    assign bus.m_addr    = m_addr;
    assign bus.m_datain  = m_datain;
    assign bus.i_done    = i_done;
    assign bus.i_dataout = i_dataout;
    assign bus.d_done    = d_done;
    assign bus.d_dataout = d_dataout;
    // Stalls are forced low while reset is held so every output reads zero.
    assign bus.i_stall   = ~rst & req_i & ~i_done;
    assign bus.d_stall   = ~rst & req_d & ~d_done;
    assign bus.err       = bus.m_err | err_q;

endmodule
